// File: rtl/commit_trace_checker_if.sv
// Trace-load and commit-observation bus feeding the commit trace checker.
// The master side is the CPU writeback taps plus the trace loader.
interface commit_trace_checker_if #(
  parameter int CHANNELS    = 1,
  parameter int DATA_WIDTH  = 32,
  parameter int TRACE_DEPTH = 1024
);
  localparam int AW      = $clog2(TRACE_DEPTH);
  localparam int ENTRY_W = 2 + 5 + 2 * DATA_WIDTH;

  logic                           trace_we;
  logic [AW-1:0]                  trace_waddr;
  logic [ENTRY_W-1:0]             trace_wdata;
  logic [CHANNELS-1:0]            obs_reg_we;
  logic [5*CHANNELS-1:0]          obs_reg_addr;
  logic [DATA_WIDTH*CHANNELS-1:0] obs_reg_data;
  logic [CHANNELS-1:0]            obs_hilo_we;
  logic [DATA_WIDTH*CHANNELS-1:0] obs_hi;
  logic [DATA_WIDTH*CHANNELS-1:0] obs_lo;

  modport master (
    output trace_we, trace_waddr, trace_wdata,
    output obs_reg_we, obs_reg_addr, obs_reg_data,
    output obs_hilo_we, obs_hi, obs_lo
  );

  modport slave (
    input trace_we, trace_waddr, trace_wdata,
    input obs_reg_we, obs_reg_addr, obs_reg_data,
    input obs_hilo_we, obs_hi, obs_lo
  );
endinterface

// File: rtl/commit_trace_checker.sv
// Compares per-cycle writeback events from CHANNELS commit ports against an
// expected trace in local memory and reports pass/fail plus the first mismatch.
//
// state  | meaning
// S_IDLE | waiting for start, trace memory writable
// S_WARM | ignoring observations for WARMUP cycles
// S_RUN  | comparing CHANNELS trace entries per cycle
// S_DONE | results held, trace memory writable, start reruns
module commit_trace_checker #(
  parameter int CHANNELS     = 1,
  parameter int DATA_WIDTH   = 32,
  parameter int TRACE_DEPTH  = 1024,
  parameter int WARMUP       = 5,
  parameter int STOP_ON_FAIL = 0,
  localparam int AW          = $clog2(TRACE_DEPTH),
  localparam int ENTRY_W     = 2 + 5 + 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  commit_trace_checker_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           mismatch_count,
  output logic [AW:0]           checked_count,
  output logic                  fail_valid,
  output logic [AW-1:0]         fail_index,
  output logic [1:0]            fail_channel,
  output logic [ENTRY_W-1:0]    fail_expected,
  output logic [ENTRY_W-1:0]    fail_got
);
  // Pointer is two bits wider than the address so ptr+c past the end never wraps.
  localparam int PW = AW + 2;
  localparam logic [PW-1:0] DEPTH_P   = PW'(TRACE_DEPTH);
  localparam logic [7:0]    WARM_LOAD = (WARMUP > 0) ? 8'(WARMUP - 1) : 8'd0;
  localparam logic [1:0]    K_REG     = 2'b01;
  localparam logic [1:0]    K_HILO    = 2'b10;
  localparam logic [1:0]    K_END     = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN, S_DONE} state_t;

  state_t             state;
  logic [ENTRY_W-1:0] mem [TRACE_DEPTH];
  logic [PW-1:0]      ptr;
  logic [7:0]         warm_cnt;

  logic [PW-1:0]      idx   [CHANNELS];
  logic [ENTRY_W-1:0] exp_e [CHANNELS];
  logic [ENTRY_W-1:0] got_e [CHANNELS];

  logic               hit_end;
  logic [2:0]         n_cmp;
  logic [2:0]         n_mis;
  logic               first_hit;
  logic [AW-1:0]      first_idx;
  logic [1:0]         first_ch;
  logic [ENTRY_W-1:0] first_exp;
  logic [ENTRY_W-1:0] first_got;

  logic [16:0]        mis_sum;
  logic [15:0]        mis_next;
  logic               stop_run;

  always_ff @(posedge clk) begin
    if (bus.trace_we && (state == S_IDLE || state == S_DONE) &&
        (PW'(bus.trace_waddr) < DEPTH_P)) begin
      mem[bus.trace_waddr] <= bus.trace_wdata;
    end
  end

  // Indices past the end of memory read back as END so the run never wraps.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      idx[c]   = ptr + PW'(c);
      exp_e[c] = (idx[c] < DEPTH_P) ? mem[idx[c][AW-1:0]]
                                    : {K_END, {(ENTRY_W-2){1'b0}}};
      if (bus.obs_reg_we[c]) begin
        got_e[c] = {K_REG, bus.obs_reg_addr[5*c +: 5],
                    bus.obs_reg_data[DATA_WIDTH*c +: DATA_WIDTH],
                    {DATA_WIDTH{1'b0}}};
      end else if (bus.obs_hilo_we[c]) begin
        got_e[c] = {K_HILO, 5'd0, bus.obs_hi[DATA_WIDTH*c +: DATA_WIDTH],
                    bus.obs_lo[DATA_WIDTH*c +: DATA_WIDTH]};
      end else begin
        got_e[c] = '0;
      end
    end
  end

  always_comb begin
    hit_end   = 1'b0;
    n_cmp     = 3'd0;
    n_mis     = 3'd0;
    first_hit = 1'b0;
    first_idx = '0;
    first_ch  = 2'd0;
    first_exp = '0;
    first_got = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (!hit_end) begin
        if (exp_e[c][ENTRY_W-1 -: 2] == K_END) begin
          hit_end = 1'b1;
        end else begin
          n_cmp = n_cmp + 3'd1;
          if (exp_e[c] != got_e[c]) begin
            n_mis = n_mis + 3'd1;
            if (!first_hit) begin
              first_hit = 1'b1;
              first_idx = idx[c][AW-1:0];
              first_ch  = 2'(c);
              first_exp = exp_e[c];
              first_got = got_e[c];
            end
          end
        end
      end
    end
  end

  assign mis_sum  = {1'b0, mismatch_count} + {14'd0, n_mis};
  assign mis_next = mis_sum[16] ? 16'hFFFF : mis_sum[15:0];
  assign stop_run = hit_end || ((STOP_ON_FAIL != 0) && (n_mis != 3'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      ptr            <= '0;
      warm_cnt       <= 8'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_count <= 16'd0;
      checked_count  <= '0;
      fail_valid     <= 1'b0;
      fail_index     <= '0;
      fail_channel   <= 2'd0;
      fail_expected  <= '0;
      fail_got       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            ptr            <= '0;
            warm_cnt       <= WARM_LOAD;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_count <= 16'd0;
            checked_count  <= '0;
            fail_valid     <= 1'b0;
            fail_index     <= '0;
            fail_channel   <= 2'd0;
            fail_expected  <= '0;
            fail_got       <= '0;
            state          <= (WARMUP == 0) ? S_RUN : S_WARM;
          end
        end
        S_WARM: begin
          if (warm_cnt == 8'd0) begin
            state <= S_RUN;
          end else begin
            warm_cnt <= warm_cnt - 8'd1;
          end
        end
        S_RUN: begin
          checked_count  <= checked_count + (AW+1)'(n_cmp);
          mismatch_count <= mis_next;
          if (first_hit && !fail_valid) begin
            fail_valid    <= 1'b1;
            fail_index    <= first_idx;
            fail_channel  <= first_ch;
            fail_expected <= first_exp;
            fail_got      <= first_got;
          end
          if (stop_run) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (mis_next == 16'd0);
          end else begin
            ptr <= ptr + PW'(CHANNELS);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_commit_trace_checker.sv
// Directed bench for commit_trace_checker: single/dual/quad-channel instances
// covering pass, mismatch, END handling, stop-on-fail, priority, saturation and reset.
module tb_commit_trace_checker;
  logic clk;
  logic rst;
  logic start1, start2, start3;
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [70:0] E_END = {2'b11, 69'd0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  commit_trace_checker_if #(.CHANNELS(1), .DATA_WIDTH(32), .TRACE_DEPTH(16))    b1 ();
  commit_trace_checker_if #(.CHANNELS(2), .DATA_WIDTH(32), .TRACE_DEPTH(16))    b2 ();
  commit_trace_checker_if #(.CHANNELS(4), .DATA_WIDTH(8),  .TRACE_DEPTH(65600)) b3 ();

  logic        o1_busy, o1_done, o1_pass, o1_fv;
  logic [15:0] o1_mis;
  logic [4:0]  o1_chk;
  logic [3:0]  o1_fi;
  logic [1:0]  o1_fc;
  logic [70:0] o1_fe, o1_fg;

  logic        o2_busy, o2_done, o2_pass, o2_fv;
  logic [15:0] o2_mis;
  logic [4:0]  o2_chk;
  logic [3:0]  o2_fi;
  logic [1:0]  o2_fc;
  logic [70:0] o2_fe, o2_fg;

  logic        o3_busy, o3_done, o3_pass, o3_fv;
  logic [15:0] o3_mis;
  logic [17:0] o3_chk;
  logic [16:0] o3_fi;
  logic [1:0]  o3_fc;
  logic [22:0] o3_fe, o3_fg;

  commit_trace_checker #(.CHANNELS(1), .DATA_WIDTH(32), .TRACE_DEPTH(16),
                         .WARMUP(5), .STOP_ON_FAIL(0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .bus(b1),
    .busy(o1_busy), .done(o1_done), .pass(o1_pass), .mismatch_count(o1_mis),
    .checked_count(o1_chk), .fail_valid(o1_fv), .fail_index(o1_fi),
    .fail_channel(o1_fc), .fail_expected(o1_fe), .fail_got(o1_fg));

  commit_trace_checker #(.CHANNELS(2), .DATA_WIDTH(32), .TRACE_DEPTH(16),
                         .WARMUP(0), .STOP_ON_FAIL(1)) u2 (
    .clk(clk), .rst(rst), .start(start2), .bus(b2),
    .busy(o2_busy), .done(o2_done), .pass(o2_pass), .mismatch_count(o2_mis),
    .checked_count(o2_chk), .fail_valid(o2_fv), .fail_index(o2_fi),
    .fail_channel(o2_fc), .fail_expected(o2_fe), .fail_got(o2_fg));

  commit_trace_checker #(.CHANNELS(4), .DATA_WIDTH(8), .TRACE_DEPTH(65600),
                         .WARMUP(2), .STOP_ON_FAIL(0)) u3 (
    .clk(clk), .rst(rst), .start(start3), .bus(b3),
    .busy(o3_busy), .done(o3_done), .pass(o3_pass), .mismatch_count(o3_mis),
    .checked_count(o3_chk), .fail_valid(o3_fv), .fail_index(o3_fi),
    .fail_channel(o3_fc), .fail_expected(o3_fe), .fail_got(o3_fg));

  function automatic logic [70:0] e_reg(input logic [4:0] a, input logic [31:0] d);
    return {2'b01, a, d, 32'h0};
  endfunction

  function automatic logic [70:0] e_hilo(input logic [31:0] hi, input logic [31:0] lo);
    return {2'b10, 5'd0, hi, lo};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic obs1(input logic rwe, input logic [4:0] ra, input logic [31:0] rd,
                      input logic hwe, input logic [31:0] hi, input logic [31:0] lo);
    b1.obs_reg_we   = rwe;
    b1.obs_reg_addr = ra;
    b1.obs_reg_data = rd;
    b1.obs_hilo_we  = hwe;
    b1.obs_hi       = hi;
    b1.obs_lo       = lo;
  endtask

  task automatic obs2(input logic [1:0] rwe, input logic [9:0] ra, input logic [63:0] rd);
    b2.obs_reg_we   = rwe;
    b2.obs_reg_addr = ra;
    b2.obs_reg_data = rd;
    b2.obs_hilo_we  = 2'b00;
    b2.obs_hi       = 64'd0;
    b2.obs_lo       = 64'd0;
  endtask

  task automatic wr1(input int a, input logic [70:0] d);
    b1.trace_we = 1'b1; b1.trace_waddr = 4'(a); b1.trace_wdata = d;
    tick();
    b1.trace_we = 1'b0;
  endtask

  task automatic wr2(input int a, input logic [70:0] d);
    b2.trace_we = 1'b1; b2.trace_waddr = 4'(a); b2.trace_wdata = d;
    tick();
    b2.trace_we = 1'b0;
  endtask

  // One u1 run over {reg $1=d0, skip, hilo 5/A, END}; optionally sets both
  // enables on the reg cycle and pokes the trace memory during warmup.
  task automatic run1(input logic [31:0] d0, input logic both, input logic poke);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("u1_busy_after_start", 128'(o1_busy), 128'(1));
    for (int i = 0; i < 5; i++) begin
      obs1(1'b1, 5'd7, 32'hDEAD, 1'b0, 32'h0, 32'h0);
      if (poke && i == 1) begin
        b1.trace_we = 1'b1; b1.trace_waddr = 4'd0; b1.trace_wdata = e_reg(5'd1, 32'hBAD);
      end
      tick();
      b1.trace_we = 1'b0;
    end
    obs1(1'b1, 5'd1, d0, both, 32'h77, 32'h88);
    tick();
    obs1(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    obs1(1'b0, 5'd0, 32'h0, 1'b1, 32'h5, 32'hA);
    tick();
    obs1(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    check("u1_done_not_early", 128'(o1_done), 128'(0));
    tick();
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
    b1.trace_we = 1'b0; b1.trace_waddr = '0; b1.trace_wdata = '0;
    b2.trace_we = 1'b0; b2.trace_waddr = '0; b2.trace_wdata = '0;
    b3.trace_we = 1'b0; b3.trace_waddr = '0; b3.trace_wdata = '0;
    obs1(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    obs2(2'b00, 10'd0, 64'd0);
    b3.obs_reg_we = 4'hF; b3.obs_reg_addr = {4{5'd1}}; b3.obs_reg_data = {4{8'h5A}};
    b3.obs_hilo_we = 4'h0; b3.obs_hi = 32'd0; b3.obs_lo = 32'd0;
    tick(); tick();
    rst = 1'b0;
    tick();

    check("rst_busy",  128'(o1_busy), 128'(0));
    check("rst_done",  128'(o1_done), 128'(0));
    check("rst_pass",  128'(o1_pass), 128'(0));
    check("rst_mis",   128'(o1_mis),  128'(0));
    check("rst_chk",   128'(o1_chk),  128'(0));
    check("rst_fv",    128'(o1_fv),   128'(0));
    check("rst_fi",    128'(o1_fi),   128'(0));

    wr1(0, e_reg(5'd1, 32'h00001100));
    wr1(1, 71'd0);
    wr1(2, e_hilo(32'h5, 32'hA));
    wr1(3, E_END);

    run1(32'h00001100, 1'b0, 1'b0);
    check("pass1_done", 128'(o1_done), 128'(1));
    check("pass1_busy", 128'(o1_busy), 128'(0));
    check("pass1_pass", 128'(o1_pass), 128'(1));
    check("pass1_chk",  128'(o1_chk),  128'(3));
    check("pass1_mis",  128'(o1_mis),  128'(0));
    check("pass1_fv",   128'(o1_fv),   128'(0));

    run1(32'h00001101, 1'b0, 1'b0);
    check("mis1_pass", 128'(o1_pass), 128'(0));
    check("mis1_mis",  128'(o1_mis),  128'(1));
    check("mis1_chk",  128'(o1_chk),  128'(3));
    check("mis1_fv",   128'(o1_fv),   128'(1));
    check("mis1_fi",   128'(o1_fi),   128'(0));
    check("mis1_fc",   128'(o1_fc),   128'(0));
    check("mis1_fg",   128'(o1_fg),   128'(e_reg(5'd1, 32'h00001101)));
    check("mis1_fe",   128'(o1_fe),   128'(e_reg(5'd1, 32'h00001100)));

    run1(32'h00001100, 1'b1, 1'b1);
    check("prio_pass", 128'(o1_pass), 128'(1));
    check("prio_mis",  128'(o1_mis),  128'(0));
    check("prio_fv",   128'(o1_fv),   128'(0));

    // Reset in the middle of a run with a mismatch already counted
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    obs1(1'b1, 5'd1, 32'h2222, 1'b0, 32'h0, 32'h0);
    tick();
    check("midrun_mis", 128'(o1_mis),  128'(1));
    check("midrun_fv",  128'(o1_fv),   128'(1));
    check("midrun_busy", 128'(o1_busy), 128'(1));
    rst = 1'b1;
    obs1(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    check("rst2_busy", 128'(o1_busy), 128'(0));
    check("rst2_done", 128'(o1_done), 128'(0));
    check("rst2_mis",  128'(o1_mis),  128'(0));
    check("rst2_chk",  128'(o1_chk),  128'(0));
    check("rst2_fv",   128'(o1_fv),   128'(0));
    check("rst2_fe",   128'(o1_fe),   128'(0));

    run1(32'h00001100, 1'b0, 1'b0);
    check("rerun_pass", 128'(o1_pass), 128'(1));
    check("rerun_chk",  128'(o1_chk),  128'(3));

    // Dual channel, END on channel 1 of the second compared cycle
    wr2(0, e_reg(5'd2, 32'h1));
    wr2(1, e_reg(5'd3, 32'h2));
    wr2(2, e_reg(5'd4, 32'h3));
    wr2(3, E_END);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("dual_busy", 128'(o2_busy), 128'(1));
    obs2(2'b11, {5'd3, 5'd2}, {32'h2, 32'h1});
    tick();
    check("dual_done_early", 128'(o2_done), 128'(0));
    obs2(2'b11, {5'd9, 5'd4}, {32'hFFFF, 32'h3});
    tick();
    obs2(2'b00, 10'd0, 64'd0);
    check("dual_done", 128'(o2_done), 128'(1));
    check("dual_pass", 128'(o2_pass), 128'(1));
    check("dual_chk",  128'(o2_chk),  128'(3));
    check("dual_mis",  128'(o2_mis),  128'(0));

    // Stop on fail: mismatch at index 1 of a 10-entry trace
    for (int i = 0; i < 10; i++) wr2(i, e_reg(5'(i + 1), 32'h100 + 32'(i)));
    wr2(10, E_END);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    obs2(2'b11, {5'd2, 5'd1}, {32'h1FF, 32'h100});
    tick();
    obs2(2'b00, 10'd0, 64'd0);
    check("sof_done", 128'(o2_done), 128'(1));
    check("sof_busy", 128'(o2_busy), 128'(0));
    check("sof_pass", 128'(o2_pass), 128'(0));
    check("sof_chk",  128'(o2_chk),  128'(2));
    check("sof_mis",  128'(o2_mis),  128'(1));
    check("sof_fi",   128'(o2_fi),   128'(1));
    check("sof_fc",   128'(o2_fc),   128'(1));
    check("sof_fe",   128'(o2_fe),   128'(e_reg(5'd2, 32'h101)));
    check("sof_fg",   128'(o2_fg),   128'(e_reg(5'd2, 32'h1FF)));

    // Saturation: 65600 skip entries against constant reg writes, end of memory as END
    for (int i = 0; i < 65600; i++) begin
      b3.trace_we = 1'b1; b3.trace_waddr = 17'(i); b3.trace_wdata = 23'd0;
      tick();
    end
    b3.trace_we = 1'b0;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int i = 0; i < 20000 && !o3_done; i++) tick();
    check("sat_done", 128'(o3_done), 128'(1));
    check("sat_mis",  128'(o3_mis),  128'(16'hFFFF));
    check("sat_chk",  128'(o3_chk),  128'(65600));
    check("sat_pass", 128'(o3_pass), 128'(0));
    check("sat_fi",   128'(o3_fi),   128'(0));
    check("sat_fc",   128'(o3_fc),   128'(0));
    check("sat_fe",   128'(o3_fe),   128'(0));
    check("sat_fg",   128'(o3_fg),   128'({2'b01, 5'd1, 8'h5A, 8'h00}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
